// File: rtl/triple_buffer_sched.sv
// triple_buffer_sched: rotates three frame buffers between a writer and a
// display. Display acts first each cycle, then the writer acts on the result.
// Optional build macro TBS_FRAME_DROP_EN: the writer is never stalled; a new
// frame replaces an undisplayed pending frame instead of being rejected.
module triple_buffer_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_frame_done,
  input  logic             rd_frame_start,
  input  logic             cnt_clr,
  output logic [1:0]       wr_sel,
  output logic [1:0]       rd_sel,
  output logic             pend_valid,
  output logic             wr_busy,
  output logic             wr_ack,
  output logic             swap_ack,
  output logic [CNT_W-1:0] swap_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [1:0] w_idx, p_idx, d_idx;
  logic [1:0] w_nxt, p_nxt, d_nxt;
  logic       pend_nxt;
  logic       swap_evt, acc_evt, drop_evt;

  // Next buffer roles: display hand-off first, then writer hand-off on the result.
  always_comb begin
    w_nxt    = w_idx;
    p_nxt    = p_idx;
    d_nxt    = d_idx;
    pend_nxt = pend_valid;
    swap_evt = 1'b0;
    acc_evt  = 1'b0;
    drop_evt = 1'b0;
    if (rd_frame_start && pend_valid) begin
      d_nxt    = p_idx;
      p_nxt    = d_idx;
      pend_nxt = 1'b0;
      swap_evt = 1'b1;
    end
    if (wr_frame_done) begin
      // A still-pending frame at this point is either overwritten or the
      // incoming one is rejected; both count as a lost frame.
      drop_evt = pend_nxt;
`ifdef TBS_FRAME_DROP_EN
      acc_evt  = 1'b1;
`else
      acc_evt  = !pend_nxt;
`endif
    end
    if (acc_evt) begin
      w_nxt    = p_nxt;
      p_nxt    = w_idx;
      pend_nxt = 1'b1;
    end
  end

  // Buffer index and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_idx      <= 2'd0;
      p_idx      <= 2'd1;
      d_idx      <= 2'd2;
      pend_valid <= 1'b0;
      wr_ack     <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      w_idx      <= w_nxt;
      p_idx      <= p_nxt;
      d_idx      <= d_nxt;
      pend_valid <= pend_nxt;
      wr_ack     <= acc_evt;
      swap_ack   <= swap_evt;
    end
  end

  // Saturating frame statistics; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      swap_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (swap_evt && (swap_cnt != '1)) swap_cnt <= swap_cnt + 1'b1;
      if (drop_evt && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign wr_sel = w_idx;
  assign rd_sel = d_idx;
`ifdef TBS_FRAME_DROP_EN
  assign wr_busy = 1'b0;
`else
  assign wr_busy = pend_valid;
`endif

endmodule

// File: tb/tb_triple_buffer_sched.sv
// Bench for triple_buffer_sched: directed vector table, hand sequences and a
// randomized run against a role-based reference model.
module tb_triple_buffer_sched;

  localparam int CW = 4;
`ifdef TBS_FRAME_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, wr_frame_done, rd_frame_start, cnt_clr;
  logic [1:0]    wr_sel, rd_sel;
  logic          pend_valid, wr_busy, wr_ack, swap_ack;
  logic [CW-1:0] swap_cnt, drop_cnt;

  int n_chk = 0;
  int n_fail = 0;

  triple_buffer_sched #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .wr_frame_done(wr_frame_done),
    .rd_frame_start(rd_frame_start), .cnt_clr(cnt_clr),
    .wr_sel(wr_sel), .rd_sel(rd_sel), .pend_valid(pend_valid),
    .wr_busy(wr_busy), .wr_ack(wr_ack), .swap_ack(swap_ack),
    .swap_cnt(swap_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic s, d, c;
    logic [1:0] w, r;
    logic pend, wack, sack;
    logic [3:0] sc, dc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic d, input logic c);
    rd_frame_start = s; wr_frame_done = d; cnt_clr = c;
    @(posedge clk); #1;
    rd_frame_start = 0; wr_frame_done = 0; cnt_clr = 0;
  endtask

  task automatic do_reset(input logic s, input logic d);
    reset = 1; rd_frame_start = s; wr_frame_done = d; cnt_clr = 0;
    @(posedge clk); #1;
    reset = 0; rd_frame_start = 0; wr_frame_done = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_sel"}, wr_sel, 0);
    chk({tag, "_rd_sel"}, rd_sel, 2);
    chk({tag, "_pend"}, pend_valid, 0);
    chk({tag, "_busy"}, wr_busy, 0);
    chk({tag, "_swap_cnt"}, swap_cnt, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  // reference model: which buffer plays each role, plus event tallies
  int m_w, m_p, m_d, m_sc, m_dc;
  bit m_pend, m_wack, m_sack;

  task automatic model_step(input bit s, input bit d, input bit c);
    int t;
    bit pre_pend;
    pre_pend = m_pend;
    m_wack = 0; m_sack = 0;
    if (s && pre_pend) begin
      t = m_d; m_d = m_p; m_p = t;
      m_pend = 0; m_sack = 1;
      m_sc = (m_sc < (1 << CW) - 1) ? m_sc + 1 : m_sc;
    end
    if (d) begin
      if (pre_pend && !s)
        m_dc = (m_dc < (1 << CW) - 1) ? m_dc + 1 : m_dc;
      if (DROP || !pre_pend || s) begin
        t = m_w; m_w = m_p; m_p = t;
        m_pend = 1; m_wack = 1;
      end
    end
    if (c) begin m_sc = 0; m_dc = 0; end
  endtask

  initial begin
    reset = 0; wr_frame_done = 0; rd_frame_start = 0; cnt_clr = 0;

    //          s  d  c  w  r  pd wa sa sc dc
    tbl[0] = '{1'b0,1'b1,1'b0,2'd1,2'd2,1'b1,1'b1,1'b0,4'd0,4'd0};
    tbl[1] = '{1'b0,1'b0,1'b0,2'd1,2'd2,1'b1,1'b0,1'b0,4'd0,4'd0};
    tbl[2] = '{1'b0,1'b0,1'b0,2'd1,2'd2,1'b1,1'b0,1'b0,4'd0,4'd0};
    tbl[3] = '{1'b1,1'b0,1'b0,2'd1,2'd0,1'b0,1'b0,1'b1,4'd1,4'd0};
    tbl[4] = '{1'b1,1'b0,1'b0,2'd1,2'd0,1'b0,1'b0,1'b0,4'd1,4'd0};
    tbl[5] = '{1'b0,1'b1,1'b0,2'd2,2'd0,1'b1,1'b1,1'b0,4'd1,4'd0};
`ifdef TBS_FRAME_DROP_EN
    tbl[6] = '{1'b0,1'b1,1'b0,2'd1,2'd0,1'b1,1'b1,1'b0,4'd1,4'd1};
    tbl[7] = '{1'b1,1'b1,1'b0,2'd0,2'd2,1'b1,1'b1,1'b1,4'd2,4'd1};
    tbl[8] = '{1'b1,1'b0,1'b1,2'd0,2'd1,1'b0,1'b0,1'b1,4'd0,4'd0};
    tbl[9] = '{1'b0,1'b0,1'b0,2'd0,2'd1,1'b0,1'b0,1'b0,4'd0,4'd0};
`else
    tbl[6] = '{1'b0,1'b1,1'b0,2'd2,2'd0,1'b1,1'b0,1'b0,4'd1,4'd1};
    tbl[7] = '{1'b1,1'b1,1'b0,2'd0,2'd1,1'b1,1'b1,1'b1,4'd2,4'd1};
    tbl[8] = '{1'b1,1'b0,1'b1,2'd0,2'd2,1'b0,1'b0,1'b1,4'd0,4'd0};
    tbl[9] = '{1'b0,1'b0,1'b0,2'd0,2'd2,1'b0,1'b0,1'b0,4'd0,4'd0};
`endif

    @(negedge clk);
    do_reset(0, 0);
    chk_reset_state("reset");

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].c);
      chk($sformatf("vec%0d_wr_sel", i), wr_sel, tbl[i].w);
      chk($sformatf("vec%0d_rd_sel", i), rd_sel, tbl[i].r);
      chk($sformatf("vec%0d_pend", i), pend_valid, tbl[i].pend);
      chk($sformatf("vec%0d_busy", i), wr_busy, DROP ? 1'b0 : tbl[i].pend);
      chk($sformatf("vec%0d_wr_ack", i), wr_ack, tbl[i].wack);
      chk($sformatf("vec%0d_swap_ack", i), swap_ack, tbl[i].sack);
      chk($sformatf("vec%0d_swap_cnt", i), swap_cnt, tbl[i].sc);
      chk($sformatf("vec%0d_drop_cnt", i), drop_cnt, tbl[i].dc);
    end

    // reset asserted together with frame events discards them
    step(0, 1, 0);
    do_reset(1, 1);
    chk_reset_state("midreset");

    // two writer frames with no display
    step(0, 1, 0);
    step(0, 1, 0);
    chk("dbl_wr_sel", wr_sel, DROP ? 0 : 1);
    chk("dbl_pend", pend_valid, 1);
    chk("dbl_busy", wr_busy, DROP ? 0 : 1);
    chk("dbl_wr_ack", wr_ack, DROP ? 1 : 0);
    chk("dbl_drop_cnt", drop_cnt, 1);

    // simultaneous done+start from w=1,p=0,d=2,pend=1
    do_reset(0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("both_wr_sel", wr_sel, 2);
    chk("both_rd_sel", rd_sel, 0);
    chk("both_pend", pend_valid, 1);
    chk("both_wr_ack", wr_ack, 1);
    chk("both_swap_ack", swap_ack, 1);
    chk("both_swap_cnt", swap_cnt, 1);
    chk("both_drop_cnt", drop_cnt, 0);

    // randomized run against the reference model
    do_reset(0, 0);
    m_w = 0; m_p = 1; m_d = 2; m_pend = 0; m_sc = 0; m_dc = 0;
    begin
      int n_sack;
      n_sack = 0;
      for (int i = 0; i < 10000; i++) begin
        bit s, d, c;
        s = ($urandom_range(0, 2) == 0);
        d = ($urandom_range(0, 1) == 0);
        c = ($urandom_range(0, 63) == 0);
        model_step(s, d, c);
        step(s, d, c);
        if (swap_ack === 1'b1) n_sack++;
        if (c) n_sack = 0;
        chk("rnd_perm", (4'(1) << wr_sel) | (4'(1) << rd_sel) | (4'(1) << dut.p_idx), 4'd7);
        chk("rnd_wr_sel", wr_sel, m_w);
        chk("rnd_rd_sel", rd_sel, m_d);
        chk("rnd_pend", pend_valid, m_pend);
        chk("rnd_busy", wr_busy, DROP ? 0 : m_pend);
        chk("rnd_wr_ack", wr_ack, m_wack);
        chk("rnd_swap_ack", swap_ack, m_sack);
        chk("rnd_swap_cnt", swap_cnt, m_sc);
        chk("rnd_drop_cnt", drop_cnt, m_dc);
        chk("rnd_swap_pulses", swap_cnt, (n_sack > (1 << CW) - 1) ? (1 << CW) - 1 : n_sack);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/triple_buffer_sched.md
TRIPLE_BUFFER_SCHED -- requirements
Module: triple_buffer_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the frame statistics counters.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_frame_done  input  1  one-cycle pulse; writer has finished a complete frame in buffer wr_sel.
REQ-005 SHALL have port rd_frame_start  input  1  one-cycle pulse; display is at a frame boundary and requests the newest frame.
REQ-006 SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-007 SHALL have port wr_sel  output  2  buffer index the writer must write.
REQ-008 SHALL have port rd_sel  output  2  buffer index the display must read.
REQ-009 SHALL have port pend_valid  output  1  a completed, undisplayed frame is held in the pending buffer.
REQ-010 SHALL have port wr_busy  output  1  writer must not signal another frame; tied 0 when TBS_FRAME_DROP_EN is defined.
REQ-011 SHALL have port wr_ack  output  1  one-cycle pulse; wr_frame_done was accepted.
REQ-012 SHALL have port swap_ack  output  1  one-cycle pulse; display moved to a new buffer.
REQ-013 SHALL have ports swap_cnt and drop_cnt  output  CNT_W  frames delivered to display / frames dropped or rejected.

Function
REQ-014 SHALL hold three 2-bit index registers w_idx, p_idx, d_idx (write, pending, display), always a permutation of {0,1,2}; value 3 never appears.
REQ-015 SHALL drive wr_sel=w_idx, rd_sel=d_idx, pend_valid, wr_busy, wr_ack, swap_ack directly from registers; all outputs change one cycle after the causing input.
REQ-016 SHALL evaluate each cycle with display-first semantics: rd_frame_start acts on the pre-cycle state, then wr_frame_done acts on the result.
REQ-017 SHALL, on rd_frame_start with pend_valid=1: swap d_idx and p_idx, clear pend_valid, pulse swap_ack, increment swap_cnt.
REQ-018 SHALL, on rd_frame_start with pend_valid=0: leave all indices unchanged, no swap_ack; display repeats its frame.
REQ-019 SHALL, on accepted wr_frame_done: swap w_idx and p_idx, set pend_valid, pulse wr_ack.
REQ-020 SHALL, on simultaneous start and done with pend_valid=1: produce d=old p, p=old w, w=old d, pend_valid=1, swap_ack and wr_ack both pulsed, no drop counted.
REQ-021 SHALL, on simultaneous start and done with pend_valid=0: produce w=old p, p=old w, d unchanged, pend_valid=1, wr_ack only.
REQ-022 SHALL saturate both counters at all-ones; cnt_clr zeroes them and wins over a same-cycle increment.

Reset
REQ-023 SHALL on reset set w_idx=0, p_idx=1, d_idx=2, pend_valid=0, wr_busy=0, wr_ack=0, swap_ack=0, swap_cnt=0, drop_cnt=0.
REQ-024 SHALL give reset priority over all inputs; events in the reset cycle are discarded, including mid-frame events.

Configuration
REQ-025 SHALL, with TBS_FRAME_DROP_EN defined: accept wr_frame_done while pend_valid=1 without start by swapping w_idx and p_idx (oldest pending frame discarded), keep pend_valid=1, increment drop_cnt; wr_busy constant 0.
REQ-026 SHALL, without TBS_FRAME_DROP_EN: drive wr_busy=pend_valid; wr_frame_done while wr_busy=1 and no same-cycle rd_frame_start is ignored (no index change, no wr_ack) and increments drop_cnt; with same-cycle start it is accepted per REQ-020.

Verification
REQ-027 SHALL cover: reset -> wr_sel=0, rd_sel=2, pend_valid=0, wr_busy=0, both counters 0.
REQ-028 SHALL cover: done at cycle N -> cycle N+1 wr_sel=1, pend_valid=1, wr_ack=1; start at N+3 -> rd_sel=0, pend_valid=0, swap_ack=1, swap_cnt=1.
REQ-029 SHALL cover: two done pulses after reset, no start -> drop mode: wr_sel=0, pend_valid=1, drop_cnt=1; no-drop mode: wr_sel=1, wr_busy=1, second wr_ack absent, drop_cnt=1.
REQ-030 SHALL cover: from w=1,p=0,d=2,pend=1, done+start same cycle -> w=2, p=1, d=0, pend_valid=1, swap_cnt+1, drop_cnt unchanged.
REQ-031 SHALL cover: start with pend_valid=0 -> indices unchanged, swap_ack=0; cnt_clr with simultaneous start -> both counters 0 next cycle.
REQ-032 SHALL cover: 10k cycles random done/start/cnt_clr -> indices always a permutation of {0,1,2}, swap_cnt equals swap_ack pulse count.
